// File: rtl/sm4_key_sched_ctrl.sv
// SM4 key-expansion sequencer: master-key capture, 32-round schedule via external T', round-key store.
// Optional padded single-word key mode is enabled with `define SM4_KEY_PAD_EN.
module sm4_key_sched_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_wr_i,
    input  logic [1:0]  key_idx_i,
    input  logic [31:0] key_word_i,
    input  logic        key_pad_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        rk_valid_o,
    output logic [31:0] tp_in_o,
    input  logic [31:0] tp_out_i,
    input  logic [4:0]  rk_rd_idx_i,
    output logic [31:0] rk_rd_data_o
);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_ROUND, S_DONE} state_e;

    localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    state_e             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [127:0]       mk_q, mk_d;
    logic [3:0][31:0]   k_q, k_d;       // k[3] = K0 ... k[0] = K3
    logic               rk_valid_q, rk_valid_d;
    logic               rk_we;
    logic [31:0]        rk_wdata;
    logic [31:0]        tp_in;
    logic [127:0]       key_src;
    logic [31:0]        rk_q [32];

    // CK byte j of round i is ((4i+j)*7) mod 256, generated from the counter
    function automatic logic [31:0] ck_of(input logic [4:0] i);
        logic [31:0] ck;
        ck = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            ck[31 - 8*j -: 8] = 8'(({3'b000, i, 2'b00} + 10'(j)) * 10'd7);
        end
        return ck;
    endfunction

`ifdef SM4_KEY_PAD_EN
    logic pad_q, pad_d;
    always_comb key_src = pad_q ? {mk_q[127:96], 96'h89ABCDEF_FEDCBA98_76543210} : mk_q;
`else
    logic unused_key_pad;
    assign unused_key_pad = key_pad_i;
    always_comb key_src = mk_q;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mk_d       = mk_q;
        k_d        = k_q;
        rk_valid_d = rk_valid_q;
`ifdef SM4_KEY_PAD_EN
        pad_d      = pad_q;
`endif
        rk_we      = 1'b0;
        rk_wdata   = k_q[3] ^ tp_out_i;
        tp_in      = '0;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                // A write in the start cycle lands in MK before INIT reads it
                if (key_wr_i) begin
                    rk_valid_d = 1'b0;
                    case (key_idx_i)
                        2'd0: mk_d[127:96] = key_word_i;
                        2'd1: mk_d[95:64]  = key_word_i;
                        2'd2: mk_d[63:32]  = key_word_i;
                        default: mk_d[31:0] = key_word_i;
                    endcase
                end
                if (start_i) begin
                    rk_valid_d = 1'b0;
                    state_d    = S_INIT;
`ifdef SM4_KEY_PAD_EN
                    pad_d      = key_pad_i;
`endif
                end
            end
            S_INIT: begin
                k_d     = key_src ^ FK;
                cnt_d   = '0;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                tp_in = k_q[2] ^ k_q[1] ^ k_q[0] ^ ck_of(cnt_q);
                rk_we = 1'b1;
                k_d   = {k_q[2], k_q[1], k_q[0], rk_wdata};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                done_o     = 1'b1;
                rk_valid_d = 1'b1;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mk_q       <= '0;
            k_q        <= '0;
            rk_valid_q <= 1'b0;
`ifdef SM4_KEY_PAD_EN
            pad_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mk_q       <= mk_d;
            k_q        <= k_d;
            rk_valid_q <= rk_valid_d;
`ifdef SM4_KEY_PAD_EN
            pad_q      <= pad_d;
`endif
        end
    end

    // Store is deliberately not reset; consumers qualify reads with rk_valid_o
    always_ff @(posedge clk) begin
        if (rst_n && rk_we) begin
            rk_q[cnt_q] <= rk_wdata;
        end
    end

    assign tp_in_o      = tp_in;
    assign rk_valid_o   = rk_valid_q;
    assign rk_rd_data_o = rk_q[rk_rd_idx_i];

endmodule

// File: tb/tb_sm4_key_sched_ctrl.sv
// Self-checking bench for sm4_key_sched_ctrl: models the T' unit and the full SM4 key schedule.
module tb_sm4_key_sched_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_wr_i;
    logic [1:0]  key_idx_i;
    logic [31:0] key_word_i;
    logic        key_pad_i;
    logic        start_i;
    logic        busy_o;
    logic        done_o;
    logic        rk_valid_o;
    logic [31:0] tp_in_o;
    logic [31:0] tp_out_i;
    logic [4:0]  rk_rd_idx_i;
    logic [31:0] rk_rd_data_o;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [127:0] mk_model;
    logic [31:0]  exp_rk [32];
    logic [31:0]  exp_tp [32];
    logic [31:0]  tp_c3;

    logic [31:0] fk [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

    logic [7:0] sbox [256] = '{
        8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
        8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
        8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
        8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
        8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
        8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
        8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
        8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
        8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
        8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
        8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
        8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
        8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
        8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
        8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
    };

    function automatic logic [31:0] tprime(input logic [31:0] x);
        logic [31:0] b;
        b = {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

    function automatic logic [31:0] ck_ref(input int r);
        logic [31:0] v;
        v = '0;
        for (int j = 0; j < 4; j++) begin
            v = (v << 8) | 32'(((4 * r + j) * 7) % 256);
        end
        return v;
    endfunction

    // Reference schedule computed directly from the SM4 round equations
    task automatic build_model(input logic [127:0] key);
        logic [31:0] k [4];
        logic [31:0] x, n;
        for (int i = 0; i < 4; i++) k[i] = key[127 - 32*i -: 32] ^ fk[i];
        for (int r = 0; r < 32; r++) begin
            x = k[1] ^ k[2] ^ k[3] ^ ck_ref(r);
            n = k[0] ^ tprime(x);
            exp_tp[r] = x;
            exp_rk[r] = n;
            k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = n;
        end
    endtask

    assign tp_out_i = tprime(tp_in_o);

    always #5 clk = ~clk;

    sm4_key_sched_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_wr_i     (key_wr_i),
        .key_idx_i    (key_idx_i),
        .key_word_i   (key_word_i),
        .key_pad_i    (key_pad_i),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .rk_valid_o   (rk_valid_o),
        .tp_in_o      (tp_in_o),
        .tp_out_i     (tp_out_i),
        .rk_rd_idx_i  (rk_rd_idx_i),
        .rk_rd_data_o (rk_rd_data_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [1:0] idx, input logic [31:0] data);
        key_wr_i = 1'b1; key_idx_i = idx; key_word_i = data;
        tick();
        key_wr_i = 1'b0;
        mk_model[127 - 32*idx -: 32] = data;
    endtask

    task automatic write_key(input logic [127:0] key);
        for (int i = 3; i >= 0; i--) write_word(2'(i), key[127 - 32*i -: 32]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        mk_model = '0;
    endtask

    // Start one expansion from IDLE and check every cycle up to and after done_o.
    // inject_c > 0 pulses start_i and key_wr_i mid-run; those must be ignored.
    task automatic run_expansion(input logic [127:0] key, input int inject_c);
        build_model(key);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            if (c == inject_c) begin
                start_i = 1'b1; key_wr_i = 1'b1; key_idx_i = 2'd1; key_word_i = $urandom;
            end
            rk_rd_idx_i = (c >= 3) ? 5'(c - 3) : 5'd0;
            #1;
            if (c == 3) tp_c3 = tp_in_o;
            chk_cnt++;
            if (busy_o !== 1'b1) $display("FAIL busy c=%0d got=%b exp=1", c, busy_o);
            else pass_cnt++;
            chk_cnt++;
            if (done_o !== (c == 34)) $display("FAIL done c=%0d got=%b exp=%b", c, done_o, c == 34);
            else pass_cnt++;
            chk_cnt++;
            if (rk_valid_o !== 1'b0) $display("FAIL valid_run c=%0d got=%b exp=0", c, rk_valid_o);
            else pass_cnt++;
            chk_cnt++;
            if (tp_in_o !== ((c >= 2 && c <= 33) ? exp_tp[c - 2] : 32'h0))
                $display("FAIL tp_in c=%0d got=%h exp=%h", c, tp_in_o,
                         (c >= 2 && c <= 33) ? exp_tp[c - 2] : 32'h0);
            else pass_cnt++;
            if (c >= 3) begin
                chk_cnt++;
                if (rk_rd_data_o !== exp_rk[c - 3])
                    $display("FAIL rk_live c=%0d got=%h exp=%h", c, rk_rd_data_o, exp_rk[c - 3]);
                else pass_cnt++;
            end
            tick();
            start_i = 1'b0; key_wr_i = 1'b0;
        end
        chk_cnt++;
        if (rk_valid_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0)
            $display("FAIL post_run valid=%b busy=%b done=%b exp=1/0/0", rk_valid_o, busy_o, done_o);
        else pass_cnt++;
        for (int i = 0; i < 32; i++) begin
            rk_rd_idx_i = 5'(i);
            #1;
            chk_cnt++;
            if (rk_rd_data_o !== exp_rk[i]) $display("FAIL rk[%0d] got=%h exp=%h", i, rk_rd_data_o, exp_rk[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || rk_valid_o !== 1'b0 || tp_in_o !== 32'h0)
            $display("FAIL reset busy=%b done=%b valid=%b tp_in=%h exp=0", busy_o, done_o, rk_valid_o, tp_in_o);
        else pass_cnt++;
    endtask

    task automatic test_known_vector();
        write_key(128'h01234567_89ABCDEF_FEDCBA98_76543210);
        run_expansion(mk_model, 0);
        rk_rd_idx_i = 5'd0; #1;
        chk_cnt++;
        if (rk_rd_data_o !== 32'hF12186F9) $display("FAIL kv_rk0 got=%h exp=F12186F9", rk_rd_data_o);
        else pass_cnt++;
        rk_rd_idx_i = 5'd1; #1;
        chk_cnt++;
        if (rk_rd_data_o !== 32'h41662B61) $display("FAIL kv_rk1 got=%h exp=41662B61", rk_rd_data_o);
        else pass_cnt++;
        rk_rd_idx_i = 5'd31; #1;
        chk_cnt++;
        if (rk_rd_data_o !== 32'h9124A012) $display("FAIL kv_rk31 got=%h exp=9124A012", rk_rd_data_o);
        else pass_cnt++;
    endtask

    task automatic test_pad();
        logic [127:0] exp_key;
        do_reset();
        write_word(2'd0, 32'h01234567);
`ifdef SM4_KEY_PAD_EN
        exp_key = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
`else
        exp_key = mk_model;
`endif
        key_pad_i = 1'b1;
        run_expansion(exp_key, 0);
        key_pad_i = 1'b0;
    endtask

    task automatic test_ignore_mid();
        write_key({$urandom, $urandom, $urandom, $urandom});
        run_expansion(mk_model, 10);
        run_expansion(mk_model, 0);
    endtask

    task automatic test_reset_mid();
        write_key({$urandom, $urandom, $urandom, $urandom});
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (16) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mk_model = '0;
        chk_cnt++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || rk_valid_o !== 1'b0 || tp_in_o !== 32'h0)
            $display("FAIL reset_mid busy=%b done=%b valid=%b tp_in=%h exp=0", busy_o, done_o, rk_valid_o, tp_in_o);
        else pass_cnt++;
        write_key({$urandom, $urandom, $urandom, $urandom});
        run_expansion(mk_model, 0);
    endtask

    task automatic test_invalidate();
        logic [31:0] w;
        write_word(2'd2, $urandom);
        chk_cnt++;
        if (rk_valid_o !== 1'b0) $display("FAIL inval got=%b exp=0", rk_valid_o);
        else pass_cnt++;
        w = $urandom;
        key_wr_i = 1'b1; key_idx_i = 2'd3; key_word_i = w;
        mk_model[31:0] = w;
        run_expansion(mk_model, 0);
    endtask

    task automatic test_back_to_back();
        logic [127:0] k2;
        write_key({$urandom, $urandom, $urandom, $urandom});
        run_expansion(mk_model, 0);
        k2 = mk_model;
        run_expansion(k2, 0);
    endtask

    // Pick K0 so that the round-1 operand K2^K3^K4 is zero, leaving CK1 alone on tp_in_o
    task automatic test_ck_zero();
        logic [31:0] k [4];
        k[1] = $urandom; k[2] = $urandom; k[3] = $urandom;
        k[0] = k[2] ^ k[3] ^ tprime(k[1] ^ k[2] ^ k[3] ^ ck_ref(0));
        write_key({k[0] ^ fk[0], k[1] ^ fk[1], k[2] ^ fk[2], k[3] ^ fk[3]});
        run_expansion(mk_model, 0);
        chk_cnt++;
        if (tp_c3 !== 32'h1C232A31) $display("FAIL ck1_tp_in got=%h exp=1C232A31", tp_c3);
        else pass_cnt++;
    endtask

    task automatic test_random_keys();
        for (int n = 0; n < 3; n++) begin
            write_key({$urandom, $urandom, $urandom, $urandom});
            run_expansion(mk_model, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; key_wr_i = 1'b0; key_idx_i = '0; key_word_i = '0;
        key_pad_i = 1'b0; start_i = 1'b0; rk_rd_idx_i = '0; mk_model = '0; tp_c3 = '0;
        test_reset();
        test_known_vector();
        test_invalidate();
        test_pad();
        test_ignore_mid();
        test_reset_mid();
        test_back_to_back();
        test_ck_zero();
        test_random_keys();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/sm4_key_sched_ctrl.md
# sm4_key_sched_ctrl

Sequencer for SM4 key expansion in the encryption accelerator. It collects the 128-bit master key from four 32-bit CPU writes, or from a single word in padded mode. It then runs the 32-round key schedule through an external combinational T' unit and stores the 32 round keys for the cipher core to read by index. It sits between the CPU-facing accelerator register interface and the SM4 round datapath.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `key_wr_i` in 1: write strobe for one master-key word.
- `key_idx_i` in 2: word index; 0 = MK[127:96] … 3 = MK[31:0].
- `key_word_i` in 32: key word data.
- `key_pad_i` in 1: sampled with `start_i`; 1 = padded single-word mode (see Configuration).
- `start_i` in 1: start expansion.
- `busy_o` out 1: expansion in progress.
- `done_o` out 1: one-cycle pulse when expansion is complete.
- `rk_valid_o` out 1: round-key store holds a complete schedule for the current key.
- `tp_in_o` out 32: operand to the T' unit (S-box followed by L').
- `tp_out_i` in 32: T' result, combinational in the same cycle.
- `rk_rd_idx_i` in 5: round-key read index.
- `rk_rd_data_o` out 32: `rk[rk_rd_idx_i]`, combinational read.

## Operation
- Master-key register MK[127:0]: `key_wr_i` writes word `key_idx_i` in IDLE only. Writes while busy are ignored.
- Any accepted key write clears `rk_valid_o` on the next edge.
- FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
- CK_i byte j (j=0 is MSB) = ((4i+j)·7) mod 256. This is computed from the round counter, with no ROM. Examples: CK0 = 00070E15, CK1 = 1C232A31.
- State machine:
  - IDLE: `start_i` → INIT. Also clears `rk_valid_o` and latches the mode.
  - INIT: K0..K3 ← (MK or padded key) XOR FK, cnt ← 0 → ROUND.
  - ROUND: `tp_in_o` = K1^K2^K3^CK_cnt; new = K0 ^ `tp_out_i`; rk[cnt] ← new; shift K0←K1, K1←K2, K2←K3, K3←new; cnt++.
  - When cnt = 31 is processed → DONE.
  - DONE: `done_o` = 1, `rk_valid_o` ← 1 → IDLE.
- `tp_in_o` = 0 outside ROUND.
- `start_i` outside IDLE is ignored.
- `key_wr_i` and `start_i` asserted in the same IDLE cycle: the write lands in MK first, then INIT uses the updated MK.
- Reset (including mid-expansion):
  - State → IDLE, cnt = 0, MK = 0.
  - `busy_o`, `done_o`, `rk_valid_o` = 0; `tp_in_o` = 0.
  - Round-key store contents are undefined until the next completed expansion.
- `rk_rd_data_o` is always driven from the store, whether or not `rk_valid_o` is set. Consumers must qualify reads with `rk_valid_o`.
- Decryption uses rk[31-i]; index reversal belongs to the consumer.

## Timing
- Edge 0 samples `start_i`.
- Edge 1 loads K0..K3.
- Edges 2..33 write rk[0]..rk[31], one per cycle.
- `done_o` is high in the cycle after edge 33.
- `rk_valid_o` rises on edge 34.
- Total: 34 cycles from the start edge to the `done_o` cycle.
- `busy_o` = 1 in INIT, ROUND and DONE.
- Back-to-back: a new `start_i` is accepted on the first IDLE cycle after DONE.
- Read latency is zero. A store write at edge N is visible from cycle N onward.
- The T' path is combinational in a single cycle: `tp_in_o` → `tp_out_i` → K registers.

## Configuration
- `SM4_KEY_PAD_EN` defined:
  - With `key_pad_i` = 1 at start, INIT uses {MK[127:96], 96'h89ABCDEFFEDCBA9876543210} in place of MK.
  - A single write to index 0 is sufficient.
- Not defined: `key_pad_i` is ignored and the full MK is always used.

## Test plan
- Key 0123456789ABCDEFFEDCBA9876543210, four writes, then start:
  - `done_o` in the 34th cycle after the start edge.
  - rk[0] = F12186F9, rk[1] = 41662B61, rk[31] = 9124A012.
  - `rk_valid_o` = 1.
- With `SM4_KEY_PAD_EN`: write index 0 = 01234567, `key_pad_i` = 1, start → same schedule (rk[0] = F12186F9, rk[31] = 9124A012).
- `start_i` and `key_wr_i` pulsed at cycle 10 of an expansion:
  - Both are ignored.
  - Schedule is unchanged and `done_o` timing is unchanged.
- `rst_n` = 0 at round 15:
  - Next edge: `busy_o` = 0, `rk_valid_o` = 0, `done_o` = 0, `tp_in_o` = 0.
  - A fresh start then completes correctly.
- After valid, write a key word → `rk_valid_o` drops next cycle. Simultaneous write and start in IDLE → the schedule reflects the new word.
- During ROUND with cnt = 1, K1^K2^K3 forced to 0 via a chosen MK → `tp_in_o` = 1C232A31.
